// File: rtl/aes_encipher_block_pkg.sv
// rtl/aes_encipher_block_pkg.sv - shared AES constants, update types and GF(2^8) helpers
package aes_encipher_block_pkg;

    localparam logic       AES_128_BIT_KEY = 1'b0;
    localparam logic       AES_256_BIT_KEY = 1'b1;

    localparam logic [3:0] AES128_ROUNDS   = 4'ha;
    localparam logic [3:0] AES256_ROUNDS   = 4'he;

    // Which transformation is applied to the state register this cycle
    typedef enum logic [2:0] {
        UPD_NONE  = 3'd0,
        UPD_INIT  = 3'd1,
        UPD_SBOX  = 3'd2,
        UPD_MAIN  = 3'd3,
        UPD_FINAL = 3'd4
    } update_t;

    // Multiply by x in GF(2^8) modulo x^8 + x^4 + x^3 + x + 1
    function automatic logic [7:0] gm2(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
    endfunction

    // Multiply by x + 1 in GF(2^8)
    function automatic logic [7:0] gm3(input logic [7:0] b);
        return gm2(b) ^ b;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - four parallel forward AES S-box byte lookups on one 32-bit word
module aes_sbox (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // Each byte of the word is substituted independently
    assign o_word = {SBOX[i_word[31:24]], SBOX[i_word[23:16]],
                     SBOX[i_word[15:8]],  SBOX[i_word[7:0]]};

endmodule

// File: rtl/aes_encipher_block.sv
// rtl/aes_encipher_block.sv - iterative AES-128/256 encipher datapath with word-serial SubBytes
module aes_encipher_block
    import aes_encipher_block_pkg::*;
(
    input  logic         clk,
    input  logic         reset_n,
    input  logic         next,
    input  logic         keylen,
    output logic [3:0]   round,
    input  logic [127:0] round_key,
    input  logic [127:0] block,
    output logic [127:0] new_block,
    output logic         ready
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_INIT = 2'd1,
        ST_SBOX = 2'd2,
        ST_MAIN = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_next;
    logic [3:0]     r_round_ctr;
    logic [3:0]     w_round_ctr_next;
    logic [1:0]     r_sword_ctr;
    logic [1:0]     w_sword_ctr_next;
    logic           r_keylen;
    logic           w_keylen_next;
    logic           r_ready;
    logic           w_ready_next;
    logic [127:0]   r_block;
    logic [127:0]   w_block_next;
    update_t        w_update;
    logic [3:0]     w_num_rounds;
    logic [31:0]    w_sbox_in;
    logic [31:0]    w_sbox_out;

    // Row r of each output column comes from column (c + r) mod 4
    function automatic logic [127:0] shiftrows(input logic [127:0] b);
        logic [31:0] w0, w1, w2, w3;
        w0 = b[127:96];
        w1 = b[95:64];
        w2 = b[63:32];
        w3 = b[31:0];
        return {w0[31:24], w1[23:16], w2[15:8], w3[7:0],
                w1[31:24], w2[23:16], w3[15:8], w0[7:0],
                w2[31:24], w3[23:16], w0[15:8], w1[7:0],
                w3[31:24], w0[23:16], w1[15:8], w2[7:0]};
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = w[31:24];
        b1 = w[23:16];
        b2 = w[15:8];
        b3 = w[7:0];
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] b);
        return {mixw(b[127:96]), mixw(b[95:64]), mixw(b[63:32]), mixw(b[31:0])};
    endfunction

    assign w_num_rounds = (r_keylen == AES_256_BIT_KEY) ? AES256_ROUNDS : AES128_ROUNDS;

    // Single S-box instance shared by all four words of the state
    aes_sbox u_sbox (
        .i_word (w_sbox_in),
        .o_word (w_sbox_out)
    );

    // Sequencing: next state, counters, ready flag and the update type for the state register
    always_comb begin
        w_state_next     = r_state;
        w_round_ctr_next = r_round_ctr;
        w_sword_ctr_next = r_sword_ctr;
        w_keylen_next    = r_keylen;
        w_ready_next     = r_ready;
        w_update         = UPD_NONE;
        case (r_state)
            ST_IDLE: begin
                if (next) begin
                    w_round_ctr_next = 4'd0;
                    w_keylen_next    = keylen;
                    w_ready_next     = 1'b0;
                    w_state_next     = ST_INIT;
                end
            end
            ST_INIT: begin
                w_update         = UPD_INIT;
                w_round_ctr_next = r_round_ctr + 4'd1;
                w_sword_ctr_next = 2'd0;
                w_state_next     = ST_SBOX;
            end
            ST_SBOX: begin
                w_update         = UPD_SBOX;
                w_sword_ctr_next = r_sword_ctr + 2'd1;
                if (r_sword_ctr == 2'd3) begin
                    w_state_next = ST_MAIN;
                end
            end
            ST_MAIN: begin
                w_sword_ctr_next = 2'd0;
                w_round_ctr_next = r_round_ctr + 4'd1;
                if (r_round_ctr < w_num_rounds) begin
                    w_update     = UPD_MAIN;
                    w_state_next = ST_SBOX;
                end else begin
                    w_update     = UPD_FINAL;
                    w_ready_next = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State datapath: select the word for the S-box and form the next state value
    always_comb begin
        w_block_next = r_block;
        case (r_sword_ctr)
            2'd0:    w_sbox_in = r_block[127:96];
            2'd1:    w_sbox_in = r_block[95:64];
            2'd2:    w_sbox_in = r_block[63:32];
            default: w_sbox_in = r_block[31:0];
        endcase
        case (w_update)
            UPD_INIT:  w_block_next = block ^ round_key;
            UPD_SBOX: begin
                case (r_sword_ctr)
                    2'd0:    w_block_next[127:96] = w_sbox_out;
                    2'd1:    w_block_next[95:64]  = w_sbox_out;
                    2'd2:    w_block_next[63:32]  = w_sbox_out;
                    default: w_block_next[31:0]   = w_sbox_out;
                endcase
            end
            UPD_MAIN:  w_block_next = mixcolumns(shiftrows(r_block)) ^ round_key;
            UPD_FINAL: w_block_next = shiftrows(r_block) ^ round_key;
            default:   w_block_next = r_block;
        endcase
    end

    // Registers; reset discards any partial result and returns to idle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_round_ctr <= 4'd0;
            r_sword_ctr <= 2'd0;
            r_keylen    <= AES_128_BIT_KEY;
            r_ready     <= 1'b1;
            r_block     <= 128'd0;
        end else begin
            r_state     <= w_state_next;
            r_round_ctr <= w_round_ctr_next;
            r_sword_ctr <= w_sword_ctr_next;
            r_keylen    <= w_keylen_next;
            r_ready     <= w_ready_next;
            r_block     <= w_block_next;
        end
    end

    assign round     = r_round_ctr;
    assign new_block = r_block;
    assign ready     = r_ready;

endmodule

// File: tb/tb_aes_encipher_block.sv
// tb/tb_aes_encipher_block.sv - self-checking bench for aes_encipher_block
module tb_aes_encipher_block;

    localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'd0};
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'd0};
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         next;
    logic         keylen;
    logic [3:0]   round;
    logic [127:0] round_key;
    logic [127:0] block;
    logic [127:0] new_block;
    logic         ready;

    logic [127:0] rk [0:15];
    logic [7:0]   sb [0:255];
    logic [3:0]   rounds_seen [0:255];
    int           n_cmp = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;

    assign round_key = rk[round];

    aes_encipher_block dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .next      (next),
        .keylen    (keylen),
        .round     (round),
        .round_key (round_key),
        .block     (block),
        .new_block (new_block),
        .ready     (ready)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        logic [7:0] bb;
        p = 8'd0; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'd0;
            if (x != 0) begin
                inv = 8'd1;
                for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
            end
            s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                    ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sb[x] = s;
        end
    endtask

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic set_key(input logic kl, input logic [255:0] key);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        int nk;
        int nr;
        nk = kl ? 8 : 4;
        nr = kl ? 14 : 10;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255 - 32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t = subword({t[23:0], t[31:24]}) ^ {rc, 24'd0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = subword(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r < 16; r++)
            rk[r] = (r <= nr) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
    endtask

    // Textbook AES on a 4x4 byte matrix, byte (row r, column c) at index 4*c + r
    function automatic logic [127:0] model_enc(input logic [127:0] pt, input int nr);
        logic [7:0] s [0:15];
        logic [7:0] t [0:15];
        logic [127:0] out;
        for (int i = 0; i < 16; i++) s[i] = pt[127 - 8*i -: 8] ^ rk[0][127 - 8*i -: 8];
        for (int rnd = 1; rnd <= nr; rnd++) begin
            for (int i = 0; i < 16; i++) s[i] = sb[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) t[4*c + r] = s[4*((c + r) % 4) + r];
            for (int c = 0; c < 4; c++) begin
                if (rnd < nr) begin
                    s[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
                    s[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
                end else begin
                    for (int r = 0; r < 4; r++) s[4*c + r] = t[4*c + r];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[rnd][127 - 8*i -: 8];
        end
        for (int i = 0; i < 16; i++) out[127 - 8*i -: 8] = s[i];
        return out;
    endfunction

    // Start one operation and count edges until ready; optional disturbances by cycle index
    task automatic do_op(input logic kl, input logic [127:0] pt, input int toggle_at,
                         input int pulse_at, input int reset_at, output int lat);
        @(negedge clk);
        keylen = kl; block = pt; next = 1'b1;
        @(posedge clk);
        @(negedge clk);
        next = 1'b0;
        lat = 0;
        rounds_seen[0] = round;
        while (lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            rounds_seen[lat] = round;
            if (ready) break;
            if (lat == toggle_at) keylen = ~keylen;
            next = (lat == pulse_at);
            if (lat == reset_at) begin
                reset_n = 1'b0;
                break;
            end
        end
        next = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++;
        if (ready !== 1'b1 || new_block !== 128'd0 || round !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b round=%h block=%h want ready=1 round=0 block=0", ready, round, new_block);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || new_block !== 128'd0) begin
            n_fail++;
            $display("FAIL idle_after_reset: ready=%b block=%h want 1 / 0", ready, new_block);
        end
    endtask

    task automatic test_fips_c1();
        int lat;
        set_key(1'b0, KEY_C1);
        do_op(1'b0, PT_C, -1, -1, -1, lat);
        n_cmp++;
        if (new_block !== CT_C1) begin
            n_fail++;
            $display("FAIL c1_data: got %h want %h", new_block, CT_C1);
        end
        n_cmp++;
        if (lat !== 51) begin
            n_fail++;
            $display("FAIL c1_latency: got %0d want 51", lat);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (ready !== 1'b1 || new_block !== CT_C1) begin
            n_fail++;
            $display("FAIL c1_hold: ready=%b block=%h want 1 / %h", ready, new_block, CT_C1);
        end
    endtask

    task automatic test_fips_c3();
        int lat;
        set_key(1'b1, KEY_C3);
        do_op(1'b1, PT_C, -1, -1, -1, lat);
        n_cmp++;
        if (new_block !== CT_C3) begin
            n_fail++;
            $display("FAIL c3_data: got %h want %h", new_block, CT_C3);
        end
        n_cmp++;
        if (lat !== 71) begin
            n_fail++;
            $display("FAIL c3_latency: got %0d want 71", lat);
        end
        for (int k = 0; k <= 70; k++) begin
            n_cmp++;
            if (rounds_seen[k] !== 4'((k + 4) / 5)) begin
                n_fail++;
                $display("FAIL c3_round_seq: cycle %0d got %0d want %0d", k, rounds_seen[k], (k + 4) / 5);
            end
        end
    endtask

    task automatic test_fips_b();
        int lat;
        set_key(1'b0, KEY_B);
        do_op(1'b0, PT_B, -1, -1, -1, lat);
        n_cmp++;
        if (new_block !== CT_B || lat !== 51) begin
            n_fail++;
            $display("FAIL appb: got %h lat %0d want %h lat 51", new_block, lat, CT_B);
        end
    endtask

    task automatic test_busy_disturb();
        int lat;
        set_key(1'b0, KEY_C1);
        do_op(1'b0, PT_C, 10, 20, -1, lat);
        n_cmp++;
        if (new_block !== CT_C1 || lat !== 51) begin
            n_fail++;
            $display("FAIL busy_result: got %h lat %0d want %h lat 51", new_block, lat, CT_C1);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            n_cmp++;
            if (ready !== 1'b1 || new_block !== CT_C1) begin
                n_fail++;
                $display("FAIL busy_no_restart: cycle %0d ready=%b block=%h want 1 / %h", k, ready, new_block, CT_C1);
            end
        end
    endtask

    task automatic test_mid_reset();
        int lat;
        set_key(1'b0, KEY_C1);
        do_op(1'b0, PT_C, -1, -1, 30, lat);
        #1;
        n_cmp++;
        if (ready !== 1'b1 || new_block !== 128'd0 || round !== 4'd0) begin
            n_fail++;
            $display("FAIL mid_reset_async: ready=%b round=%h block=%h want 1 / 0 / 0", ready, round, new_block);
        end
        @(negedge clk);
        reset_n = 1'b1;
        do_op(1'b0, PT_C, -1, -1, -1, lat);
        n_cmp++;
        if (new_block !== CT_C1 || lat !== 51) begin
            n_fail++;
            $display("FAIL mid_reset_rerun: got %h lat %0d want %h lat 51", new_block, lat, CT_C1);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_rdy;
        set_key(1'b0, KEY_C1);
        @(negedge clk);
        keylen = 1'b0; block = PT_C; next = 1'b1;
        for (int k = 0; k <= 155; k++) begin
            @(posedge clk);
            @(negedge clk);
            exp_rdy = (k % 52 == 51);
            n_cmp++;
            if (ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL b2b_ready: edge %0d got %b want %b", k, ready, exp_rdy);
            end
            if (exp_rdy) begin
                n_cmp++;
                if (new_block !== CT_C1) begin
                    n_fail++;
                    $display("FAIL b2b_data: edge %0d got %h want %h", k, new_block, CT_C1);
                end
            end
            if (k == 155) next = 1'b0;
        end
    endtask

    task automatic test_random();
        int lat;
        logic kl;
        logic [255:0] key;
        logic [127:0] pt;
        logic [127:0] exp;
        for (int n = 0; n < 6; n++) begin
            kl  = 1'($urandom_range(0, 1));
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom, $urandom, $urandom};
            set_key(kl, key);
            exp = model_enc(pt, kl ? 14 : 10);
            do_op(kl, pt, -1, -1, -1, lat);
            n_cmp++;
            if (new_block !== exp || lat !== (kl ? 71 : 51)) begin
                n_fail++;
                $display("FAIL random_%0d: keylen %b got %h lat %0d want %h lat %0d",
                         n, kl, new_block, lat, exp, kl ? 71 : 51);
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        next    = 1'b0;
        keylen  = 1'b0;
        block   = 128'd0;
        for (int r = 0; r < 16; r++) rk[r] = 128'd0;
        build_sbox();
        repeat (3) @(negedge clk);
        test_reset();
        test_fips_c1();
        test_fips_c3();
        test_fips_b();
        test_busy_disturb();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
